// File: rtl/blob_pkg.sv
// Shared types and default geometry for the blob labelling pipeline and its
// frame sequencer.
package blob_pkg;

  localparam int IMG_COL_DEF     = 800;
  localparam int IMG_ROW_DEF     = 600;
  localparam int FLUSH_CYC_DEF   = 200;
  localparam int RESOLVE_MAX_DEF = 262144;
  localparam int BLOB_CNT_W      = 8;

  typedef logic [BLOB_CNT_W-1:0] blob_count_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_STREAM,
    S_FLUSH,
    S_RESOLVE,
    S_DONE
  } blob_ctrl_state_e;

endpackage

// File: rtl/blob_frame_ctrl_if.sv
// Camera-side pixel stream plus the control/result signals of the blob
// labelling pipeline, as seen by the frame sequencer (master) and its peer.
interface blob_frame_ctrl_if #(
  parameter int CNT_W = blob_pkg::BLOB_CNT_W
);
  // o_blob_valid frames the whole capture+flush window, o_blob_data_valid
  // qualifies o_blob_seq per cycle, i_blob_valid is a one-cycle result strobe;
  // there is no backpressure in either direction.
  logic             i_sof;
  logic             i_pix_valid;
  logic             i_pix_bin;
  logic             o_blob_valid;
  logic             o_blob_data_valid;
  logic             o_blob_proc;
  logic             o_blob_seq;
  logic             i_blob_valid;
  logic [CNT_W-1:0] i_blob_count;

  modport master (
    input  i_sof, i_pix_valid, i_pix_bin, i_blob_valid, i_blob_count,
    output o_blob_valid, o_blob_data_valid, o_blob_proc, o_blob_seq
  );

  modport slave (
    output i_sof, i_pix_valid, i_pix_bin, i_blob_valid, i_blob_count,
    input  o_blob_valid, o_blob_data_valid, o_blob_proc, o_blob_seq
  );

endinterface

// File: rtl/blob_pix_counter.sv
// Column/row position of the next pixel in a frame; flags when that pixel is
// the last one of the frame.
module blob_pix_counter #(
  parameter int IMG_COL = blob_pkg::IMG_COL_DEF,
  parameter int IMG_ROW = blob_pkg::IMG_ROW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic last
);

  localparam int CW = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int RW = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROW - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // A pixel accepted together with clear is pixel (0,0), so the next is (0,1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= advance ? CW'(1) : '0;
      row <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/blob_frame_ctrl.sv
// Per-frame sequencer for the blob labelling pipeline: gates one frame in,
// flushes, waits for the result and latches the blob count.
// Define BLOB_FRAME_CTRL_CONT_EN for continuous (free-running) frame mode.
module blob_frame_ctrl
  import blob_pkg::*;
#(
  parameter int IMG_COL     = IMG_COL_DEF,
  parameter int IMG_ROW     = IMG_ROW_DEF,
  parameter int FLUSH_CYC   = FLUSH_CYC_DEF,
  parameter int RESOLVE_MAX = RESOLVE_MAX_DEF,
  parameter int CNT_W       = BLOB_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  blob_frame_ctrl_if.master   bus,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_timeout,
  output logic                o_resync,
  output blob_ctrl_state_e    o_state
);

  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam int RW = (RESOLVE_MAX > 1) ? $clog2(RESOLVE_MAX) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC);
  localparam logic [RW-1:0] RES_LAST   = RW'(RESOLVE_MAX - 1);

  blob_ctrl_state_e state;
  logic [FW-1:0]    flush_cnt;
  logic [RW-1:0]    res_cnt;
  logic             pix_adv;
  logic             pix_clr;
  logic             pix_last;

  assign pix_adv = !i_abort && (state == S_STREAM) && bus.i_pix_valid;
  assign pix_clr = !i_abort && bus.i_sof &&
                   ((state == S_WAIT_SOF) || (state == S_STREAM));

  blob_pix_counter #(
    .IMG_COL (IMG_COL),
    .IMG_ROW (IMG_ROW)
  ) u_pix_counter (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (pix_clr),
    .advance (pix_adv),
    .last    (pix_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= S_IDLE;
      flush_cnt             <= '0;
      res_cnt               <= '0;
      bus.o_blob_valid      <= 1'b0;
      bus.o_blob_data_valid <= 1'b0;
      bus.o_blob_proc       <= 1'b0;
      bus.o_blob_seq        <= 1'b0;
      o_done                <= 1'b0;
      o_count               <= '0;
      o_timeout             <= 1'b0;
      o_resync              <= 1'b0;
    end else begin
      o_done                <= 1'b0;
      o_resync              <= 1'b0;
      bus.o_blob_data_valid <= 1'b0;
      if (i_abort) begin
        state            <= S_IDLE;
        bus.o_blob_valid <= 1'b0;
        bus.o_blob_proc  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              state     <= S_WAIT_SOF;
              o_timeout <= 1'b0;
            end
          end
          S_WAIT_SOF: begin
            if (bus.i_sof) begin
              state            <= S_STREAM;
              bus.o_blob_valid <= 1'b1;
              bus.o_blob_proc  <= 1'b1;
`ifdef BLOB_FRAME_CTRL_CONT_EN
              o_timeout        <= 1'b0;
`endif
            end
          end
          S_STREAM: begin
            if (bus.i_pix_valid) begin
              bus.o_blob_data_valid <= 1'b1;
              bus.o_blob_seq        <= bus.i_pix_bin;
            end
            // A mid-frame SOF restarts the position count; the pipeline keeps running.
            if (bus.i_sof) begin
              o_resync <= 1'b1;
            end else if (bus.i_pix_valid && pix_last) begin
              state     <= S_FLUSH;
              flush_cnt <= '0;
            end
          end
          S_FLUSH: begin
            // The last pixel is still on the bus in the first FLUSH cycle,
            // so the state lasts one cycle longer than the data-less window.
            if (flush_cnt == FLUSH_LAST) begin
              state            <= S_RESOLVE;
              bus.o_blob_valid <= 1'b0;
              res_cnt          <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
          S_RESOLVE: begin
            if (bus.i_blob_valid) begin
              state           <= S_DONE;
              o_count         <= bus.i_blob_count;
              o_done          <= 1'b1;
              bus.o_blob_proc <= 1'b0;
            end else if (res_cnt == RES_LAST) begin
              state           <= S_DONE;
              o_timeout       <= 1'b1;
              o_done          <= 1'b1;
              bus.o_blob_proc <= 1'b0;
            end else begin
              res_cnt <= res_cnt + 1'b1;
            end
          end
          S_DONE: begin
`ifdef BLOB_FRAME_CTRL_CONT_EN
            state <= S_WAIT_SOF;
`else
            state <= S_IDLE;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy  = (state != S_IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_blob_frame_ctrl.sv
// Directed/randomised bench for blob_frame_ctrl on an 8x4 frame with a stub
// pipeline that answers after a programmable number of RESOLVE cycles.
module tb_blob_frame_ctrl;
  import blob_pkg::*;

  localparam int COLS    = 8;
  localparam int ROWS    = 4;
  localparam int NPIX    = COLS * ROWS;
  localparam int FLUSH   = 5;
  localparam int RES_MAX = 50;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic [7:0] count;
  logic timeout;
  logic resync;
  blob_ctrl_state_e state;

  blob_frame_ctrl_if bus ();

  blob_frame_ctrl #(
    .IMG_COL     (COLS),
    .IMG_ROW     (ROWS),
    .FLUSH_CYC   (FLUSH),
    .RESOLVE_MAX (RES_MAX),
    .CNT_W       (8)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_abort   (abort),
    .bus       (bus),
    .o_busy    (busy),
    .o_done    (done),
    .o_count   (count),
    .o_timeout (timeout),
    .o_resync  (resync),
    .o_state   (state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [0:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int dv_cnt, dv_no_valid, flush_obs, res_cyc, done_cnt, resync_cnt, pix_left;
  int stub_delay;
  logic [7:0] stub_count;
  logic [7:0] model_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; observe just after the edge and drive the stub for the next one.
  task automatic tick();
    logic exp_b;
    @(posedge clk);
    #1;
    if (bus.o_blob_data_valid) begin
      dv_cnt++;
      if (!bus.o_blob_valid) dv_no_valid++;
      if (exp_q.size() == 0) begin
        check("seq_extra", 32'd1, 32'd0);
      end else begin
        exp_b = exp_q.pop_front();
        check("seq", {31'd0, bus.o_blob_seq}, {31'd0, exp_b});
      end
      if (pix_left > 0) pix_left--;
    end else if (bus.o_blob_valid && pix_left == 0) begin
      flush_obs++;
    end
    if (bus.o_blob_proc && !bus.o_blob_valid) res_cyc++;
    if (done) done_cnt++;
    if (resync) resync_cnt++;
    bus.i_blob_valid = (stub_delay != 0) && bus.o_blob_proc && !bus.o_blob_valid &&
                       (res_cyc == stub_delay);
    bus.i_blob_count = stub_count;
  endtask

  task automatic new_frame(input int n_dv, input int delay, input logic [7:0] cnt);
    dv_cnt = 0; dv_no_valid = 0; flush_obs = 0; res_cyc = 0;
    done_cnt = 0; resync_cnt = 0;
    pix_left = n_dv;
    stub_delay = delay;
    stub_count = cnt;
    exp_q.delete();
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("timeout_cleared_by_start", {31'd0, timeout}, 32'd0);
  endtask

  task automatic sof_pulse();
    bus.i_sof = 1'b1;
    tick();
    bus.i_sof = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int gap_max, input bit sof_first);
    int g;
    logic b;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, gap_max);
      bus.i_pix_valid = 1'b0;
      repeat (g) tick();
      b = 1'($urandom_range(0, 1));
      bus.i_pix_valid = 1'b1;
      bus.i_pix_bin   = b;
      bus.i_sof       = sof_first && (i == 0);
      exp_q.push_back(b);
      tick();
      bus.i_sof = 1'b0;
    end
    bus.i_pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick();
      i++;
    end
    check("done_seen", {31'd0, done_cnt != d0}, 32'd1);
  endtask

  task automatic check_frame(input int exp_dv, input int exp_res,
                             input logic [7:0] exp_cnt, input logic exp_to);
    check("dv_pulses", dv_cnt, exp_dv);
    check("flush_cycles", flush_obs, FLUSH);
    check("resolve_cycles", res_cyc, exp_res);
    check("count", {24'd0, count}, {24'd0, exp_cnt});
    check("timeout", {31'd0, timeout}, {31'd0, exp_to});
    check("done_pulses", done_cnt, 1);
    check("dv_outside_valid", dv_no_valid, 0);
    check("seq_left", exp_q.size(), 0);
  endtask

  // After the DONE cycle: done must be a single pulse; the sequencer idles
  // (single-shot) or re-arms on its own (continuous), in which case abort it.
  task automatic after_done();
    tick();
    check("done_width", {31'd0, done}, 32'd0);
`ifdef BLOB_FRAME_CTRL_CONT_EN
    check("busy_rearmed", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_count"}, {24'd0, count}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_resync"}, {31'd0, resync}, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.o_blob_valid}, 32'd0);
    check({tag, "_dv"}, {31'd0, bus.o_blob_data_valid}, 32'd0);
    check({tag, "_proc"}, {31'd0, bus.o_blob_proc}, 32'd0);
    check({tag, "_seq"}, {31'd0, bus.o_blob_seq}, 32'd0);
  endtask

  initial begin
    int d;
    logic [7:0] c;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bus.i_sof = 1'b0; bus.i_pix_valid = 1'b0; bus.i_pix_bin = 1'b0;
    bus.i_blob_valid = 1'b0; bus.i_blob_count = '0;
    new_frame(0, 0, 8'd0);
    model_count = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", {29'd0, state}, {29'd0, S_IDLE});
    @(negedge clk) rst_n = 1'b1;
    tick();

    // nominal frame, result after 10 RESOLVE cycles
    new_frame(NPIX, 10, 8'd7);
    start_frame();
    sof_pulse();
    send_pixels(NPIX, 0, 1'b0);
    wait_done(200);
    model_count = 8'd7;
    check_frame(NPIX, 10, model_count, 1'b0);
    after_done();

    // gapped stream with a random result latency
    d = $urandom_range(1, 40);
    c = 8'($urandom_range(0, 255));
    new_frame(NPIX, d, c);
    start_frame();
    sof_pulse();
    send_pixels(NPIX, 3, 1'b0);
    wait_done(200);
    model_count = c;
    check_frame(NPIX, d, model_count, 1'b0);
    after_done();

    // no result: timeout after RES_MAX cycles, count kept
    new_frame(NPIX, 0, 8'hEE);
    start_frame();
    sof_pulse();
    send_pixels(NPIX, 1, 1'b0);
    wait_done(200);
    check_frame(NPIX, RES_MAX, model_count, 1'b1);
    after_done();
    check("timeout_sticky", {31'd0, timeout}, 32'd1);

    // result on the timeout cycle wins; start also clears the sticky timeout
    new_frame(NPIX, RES_MAX, 8'hA5);
    start_frame();
    sof_pulse();
    send_pixels(NPIX, 0, 1'b0);
    wait_done(200);
    model_count = 8'hA5;
    check_frame(NPIX, RES_MAX, model_count, 1'b0);
    after_done();

    // mid-frame SOF alone after 12 pixels: a full frame must follow
    c = 8'($urandom_range(0, 255));
    new_frame(12 + NPIX, 3, c);
    start_frame();
    sof_pulse();
    send_pixels(12, 1, 1'b0);
    sof_pulse();
    send_pixels(NPIX, 1, 1'b0);
    wait_done(200);
    model_count = c;
    check_frame(12 + NPIX, 3, model_count, 1'b0);
    check("resync_pulses", resync_cnt, 1);
    after_done();

    // mid-frame SOF together with a pixel: that pixel is (0,0)
    c = 8'($urandom_range(0, 255));
    new_frame(5 + NPIX, 6, c);
    start_frame();
    sof_pulse();
    send_pixels(5, 0, 1'b0);
    send_pixels(NPIX, 2, 1'b1);
    wait_done(200);
    model_count = c;
    check_frame(5 + NPIX, 6, model_count, 1'b0);
    check("resync_pulses_px", resync_cnt, 1);
    after_done();

    // abort during FLUSH
    new_frame(NPIX, 4, 8'h11);
    start_frame();
    sof_pulse();
    send_pixels(NPIX, 0, 1'b0);
    tick();
    tick();
    check("in_flush_valid", {31'd0, bus.o_blob_valid}, 32'd1);
    check("in_flush_dv", {31'd0, bus.o_blob_data_valid}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", {31'd0, bus.o_blob_valid}, 32'd0);
    check("abort_dv", {31'd0, bus.o_blob_data_valid}, 32'd0);
    check("abort_proc", {31'd0, bus.o_blob_proc}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (60) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_count_kept", {24'd0, count}, {24'd0, model_count});
    check("abort_timeout_kept", {31'd0, timeout}, 32'd0);

    // asynchronous reset in the middle of RESOLVE
    new_frame(NPIX, 0, 8'h00);
    start_frame();
    sof_pulse();
    send_pixels(NPIX, 0, 1'b0);
    for (int i = 0; i < 100 && res_cyc < 5; i++) tick();
    check("resolve_reached", {31'd0, res_cyc >= 5}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    model_count = 8'd0;
    tick();

`ifdef BLOB_FRAME_CTRL_CONT_EN
    // two back-to-back frames from one start; first times out, second clears it at SOF
    new_frame(NPIX, 0, 8'h00);
    start_frame();
    sof_pulse();
    send_pixels(NPIX, 0, 1'b0);
    wait_done(200);
    check_frame(NPIX, RES_MAX, model_count, 1'b1);
    tick();
    new_frame(NPIX, 8, 8'h3C);
    sof_pulse();
    check("timeout_cleared_by_sof", {31'd0, timeout}, 32'd0);
    send_pixels(NPIX, 1, 1'b0);
    wait_done(200);
    model_count = 8'h3C;
    check_frame(NPIX, 8, model_count, 1'b0);
    tick();
    check("cont_still_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cont_abort_idle", {31'd0, busy}, 32'd0);
`else
    // without start, SOF and pixels are ignored
    new_frame(0, 0, 8'h00);
    sof_pulse();
    send_pixels(6, 0, 1'b0);
    tick();
    check("idle_ignores_dv", dv_cnt, 0);
    check("idle_ignores_busy", {31'd0, busy}, 32'd0);
    check("idle_ignores_valid", {31'd0, bus.o_blob_valid}, 32'd0);
    exp_q.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
